muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage beside the ALU. It accepts one operation per `start` pulse, holds `busy` for a configurable latency, then commits to HI/LO. Over the fixed 32-bit, fixed-latency unit it adds width and latency parameters, multiply-accumulate modes, a `flush` abort for exception handling, and defined divide-by-zero and overflow behaviour. The hazard unit stalls D-stage mul/div/mf instructions on `start | busy`.

## Interface
- WIDTH, 32, operand and HI/LO width
- MUL_CYCLES, 5, cycles `busy` stays high for MULT/MULTU/MADD*/MSUB*; must be ≥ 1
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU; must be ≥ 1

- Clk  in  1  clock, rising edge
- Reset  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  launch `op` this cycle (one-cycle pulse from E stage)
- op  in  4  operation code from shared package
- A  in  WIDTH  rs operand (forwarded)
- B  in  WIDTH  rt operand (forwarded)
- flush  in  1  abort in-flight operation; HI/LO keep pre-operation values
- busy  out  1  operation in flight
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO; other codes are no-ops.
- States: IDLE, RUN. Reset → IDLE; HI=0, LO=0, busy=0, counter=0.
- IDLE + start + mul/div op (flush=0): capture result into pending regs {p_hi,p_lo}, load counter with MUL_CYCLES or DIV_CYCLES, go RUN.
- IDLE + start + MTHI/MTLO: write A into HI/LO at that edge; stay IDLE; busy never rises.
- RUN: counter decrements each cycle; at the edge where counter reaches 1, commit {HI,LO}={p_hi,p_lo} and return to IDLE.
- MULT/MULTU: {HI,LO} = A×B, signed/unsigned, 2·WIDTH result.
- MADD/MSUB(U): {HI,LO} = {HI,LO} ± A×B, using HI/LO as sampled at start; modulo 2^(2·WIDTH).
- DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, sign of dividend.
- B=0 on DIV/DIVU: full DIV_CYCLES latency, HI/LO unchanged at commit.
- DIV with A=most-negative, B=−1: LO=A, HI=0.
- start while RUN: ignored; the hazard unit guarantees this cannot occur.
- flush: in any state → IDLE at next edge, busy=0, pending discarded, HI/LO unchanged. flush overrides a same-cycle start, including MTHI/MTLO.
- Reset during RUN: immediate IDLE, HI=LO=0.

## Timing
- start sampled at edge k → busy=1 during cycles k+1 … k+N (N = MUL_CYCLES or DIV_CYCLES); HI/LO new values visible after edge k+N; busy=0 from then.
- Back-to-back: new start accepted in the first cycle busy=0.
- MTHI/MTLO: zero latency, visible after edge k.
- HI/LO are register outputs; no combinational path from inputs to outputs.
- Counter width = $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).

## Structure
- Shared package `mdu_pkg`: op code localparams (4-bit), helper predicates is_mul/is_div/is_mt.
- Sub-module `muldiv_datapath`: combinational product, accumulate and divide, producing {p_hi,p_lo} including the div-by-zero and overflow cases. `muldiv_unit` owns the FSM, counter and HI/LO registers.

## Test plan
- Reset release, then MULT A=−3 B=7 → busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy low.
- DIVU A=100 B=7 → busy 10 cycles; LO=14, HI=2. Then DIV A=−7 B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 1, MTLO 2, then MADDU A=3 B=4 → HI=1, LO=14 after 5 cycles; MTHI causes no busy.
- DIV B=0 with HI=5, LO=6 → busy 10 cycles; HI=5, LO=6. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MULT started, flush in cycle 3 of busy → busy=0 next cycle; HI/LO unchanged. flush together with start MTLO 9 → LO unchanged.
- Reset asserted mid-DIV → busy=0, HI=LO=0 immediately. Rerun with WIDTH=16, MUL_CYCLES=1: MULTU 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001 after 1 busy cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// op codes, FSM state type and op-class predicates.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT)  || (op == OP_MULTU) ||
           (op == OP_MADD)  || (op == OP_MADDU) ||
           (op == OP_MSUB)  || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational result path: product, accumulate
// and divide, with div-by-zero and overflow cases.
module muldiv_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_p_hi,
  output logic [WIDTH-1:0] o_p_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] W_MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] W_ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic                    w_sgn;
  logic                    w_zero;
  logic                    w_ovf;
  logic [W2-1:0]           w_ea;
  logic [W2-1:0]           w_eb;
  logic [W2-1:0]           w_prod;
  logic [W2-1:0]           w_acc;
  logic [WIDTH-1:0]        w_dv;
  logic signed [WIDTH-1:0] w_qs;
  logic signed [WIDTH-1:0] w_rs;
  logic [WIDTH-1:0]        w_q;
  logic [WIDTH-1:0]        w_r;

  // Extend operands to 2W so one multiplier covers
  // both signednesses; low 2W bits are exact.
  always_comb begin
    w_sgn = is_signed(i_op);
    w_ea  = w_sgn ? {{WIDTH{i_a[WIDTH-1]}}, i_a}
                  : {{WIDTH{1'b0}}, i_a};
    w_eb  = w_sgn ? {{WIDTH{i_b[WIDTH-1]}}, i_b}
                  : {{WIDTH{1'b0}}, i_b};
    w_prod = w_ea * w_eb;
    w_acc  = {i_hi, i_lo};
  end

  // Divide by one on zero/overflow: keeps the
  // divider well-defined and MIN/1 gives q=MIN,r=0.
  always_comb begin
    w_zero = (i_b == '0);
    w_ovf  = w_sgn && (i_a == W_MIN) && (i_b == '1);
    w_dv   = (w_zero || w_ovf) ? W_ONE : i_b;
    w_qs   = $signed(i_a) / $signed(w_dv);
    w_rs   = $signed(i_a) % $signed(w_dv);
    w_q    = w_sgn ? $unsigned(w_qs) : (i_a / w_dv);
    w_r    = w_sgn ? $unsigned(w_rs) : (i_a % w_dv);
  end

  // Select the pending result; unknown ops and
  // div-by-zero leave HI/LO as they were.
  always_comb begin
    {o_p_hi, o_p_lo} = w_acc;
    unique case (1'b1)
      (i_op == OP_MULT) || (i_op == OP_MULTU):
        {o_p_hi, o_p_lo} = w_prod;
      (i_op == OP_MADD) || (i_op == OP_MADDU):
        {o_p_hi, o_p_lo} = w_acc + w_prod;
      (i_op == OP_MSUB) || (i_op == OP_MSUBU):
        {o_p_hi, o_p_lo} = w_acc - w_prod;
      is_div(i_op):
        if (!w_zero) {o_p_hi, o_p_lo} = {w_r, w_q};
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mul/div unit: FSM, latency counter,
// pending result and architectural HI/LO registers.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES)
                      ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_load;
  logic             w_commit;
  logic             w_wr_hi;
  logic             w_wr_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_phi;
  logic [WIDTH-1:0] r_plo;
  logic [WIDTH-1:0] w_phi;
  logic [WIDTH-1:0] w_plo;

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .i_op   (op),
    .i_a    (A),
    .i_b    (B),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .o_p_hi (w_phi),
    .o_p_lo (w_plo)
  );

  // Next state, counter and write strobes;
  // flush beats any same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul(op) || is_div(op)) begin
              w_load      = 1'b1;
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = is_div(op) ? DIV_N : MUL_N;
            end
            w_wr_hi = (op == OP_MTHI);
            w_wr_lo = (op == OP_MTLO);
          end
        end
        ST_RUN: begin
          w_cnt_nxt = r_cnt - ONE;
          if (r_cnt == ONE) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and latency counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pending result captured at launch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_phi <= '0;
      r_plo <= '0;
    end else if (w_load) begin
      r_phi <= w_phi;
      r_plo <= w_plo;
    end
  end

  // Architectural HI/LO: commit or MTHI/MTLO.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= r_phi;
      r_lo <= r_plo;
    end else begin
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit
// instance and a 16-bit single-cycle-mul instance.
module tb_muldiv_unit;
  import mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st1, fl1, busy1;
  logic [3:0]  op1;
  logic [31:0] a1, b1, hi1, lo1;
  logic        st2, fl2, busy2;
  logic [3:0]  op2;
  logic [15:0] a2, b2, hi2, lo2;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t pq1[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic pb1 = 1'b0;
  logic pb2 = 1'b0;
  int   bc1 = 0;
  int   bc2 = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)
  ) dut (
    .Clk(clk), .Reset(rst_n), .start(st1),
    .op(op1), .A(a1), .B(b1), .flush(fl1),
    .busy(busy1), .HI(hi1), .LO(lo1)
  );

  muldiv_unit #(
    .WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)
  ) dut16 (
    .Clk(clk), .Reset(rst_n), .start(st2),
    .op(op2), .A(a2), .B(b2), .flush(fl2),
    .busy(busy2), .HI(hi2), .LO(lo2)
  );

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
  endtask

  function automatic exp_t mk(string n, logic [31:0] h,
                              logic [31:0] l, int c);
    exp_t e;
    e.name = n;
    e.hi   = h;
    e.lo   = l;
    e.cyc  = c;
    return e;
  endfunction

  // Monitor for the 32-bit unit: completion on busy fall,
  // idle probes whenever one is queued.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (pb1 && !busy1) begin
      if (sb1.size() == 0) begin
        check("sb1_unexpected_done", 32'd0, 32'd1);
      end else begin
        e = sb1.pop_front();
        check({e.name, "_hi"}, hi1, e.hi);
        check({e.name, "_lo"}, lo1, e.lo);
        if (e.cyc >= 0)
          check({e.name, "_busycyc"}, bc1, e.cyc);
      end
      bc1 = 0;
    end
    if (busy1) bc1++;
    pb1 = busy1;
    if (pq1.size() > 0) begin
      e = pq1.pop_front();
      check({e.name, "_hi"}, hi1, e.hi);
      check({e.name, "_lo"}, lo1, e.lo);
      check({e.name, "_busy"}, {31'd0, busy1}, 32'd0);
    end
  end

  // Monitor for the 16-bit unit.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (pb2 && !busy2) begin
      if (sb2.size() == 0) begin
        check("sb2_unexpected_done", 32'd0, 32'd1);
      end else begin
        e = sb2.pop_front();
        check({e.name, "_hi"}, {16'd0, hi2}, e.hi);
        check({e.name, "_lo"}, {16'd0, lo2}, e.lo);
        if (e.cyc >= 0)
          check({e.name, "_busycyc"}, bc2, e.cyc);
      end
      bc2 = 0;
    end
    if (busy2) bc2++;
    pb2 = busy2;
  end

  task automatic issue(int sel, logic [3:0] o,
                       logic [31:0] a, logic [31:0] b,
                       logic fl);
    if (sel == 0) begin
      st1 = 1'b1; op1 = o; a1 = a; b1 = b; fl1 = fl;
    end else begin
      st2 = 1'b1; op2 = o; a2 = a[15:0]; b2 = b[15:0];
    end
    @(posedge clk); #1;
    st1 = 1'b0;
    st2 = 1'b0;
    fl1 = 1'b0;
  endtask

  task automatic wait_idle(int sel, string name);
    int n = 0;
    while (((sel == 0) ? busy1 : busy2) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_chk++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0",
               name, n);
    end
  endtask

  task automatic probe(string n, logic [31:0] h,
                       logic [31:0] l);
    pq1.push_back(mk(n, h, l, 0));
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic run1(string n, logic [3:0] o,
                      logic [31:0] a, logic [31:0] b,
                      logic [31:0] h, logic [31:0] l,
                      int c);
    sb1.push_back(mk(n, h, l, c));
    issue(0, o, a, b, 1'b0);
    wait_idle(0, n);
  endtask

  task automatic run2(string n, logic [3:0] o,
                      logic [31:0] a, logic [31:0] b,
                      logic [31:0] h, logic [31:0] l,
                      int c);
    sb2.push_back(mk(n, h, l, c));
    issue(1, o, a, b, 1'b0);
    wait_idle(1, n);
  endtask

  initial begin
    rst_n = 1'b0;
    st1 = 0; fl1 = 0; op1 = OP_NOP; a1 = 0; b1 = 0;
    st2 = 0; fl2 = 0; op2 = OP_NOP; a2 = 0; b2 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    probe("reset", 32'h0, 32'h0);

    run1("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7,
         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run1("divu", OP_DIVU, 32'd100, 32'd7,
         32'd2, 32'd14, 10);
    run1("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

    issue(0, OP_MTHI, 32'd1, 32'd0, 1'b0);
    probe("mthi", 32'd1, 32'hFFFF_FFFD);
    issue(0, OP_MTLO, 32'd2, 32'd0, 1'b0);
    probe("mtlo", 32'd1, 32'd2);
    run1("maddu", OP_MADDU, 32'd3, 32'd4,
         32'd1, 32'd14, 5);

    issue(0, OP_MTHI, 32'd5, 32'd0, 1'b0);
    issue(0, OP_MTLO, 32'd6, 32'd0, 1'b0);
    run1("div_zero", OP_DIV, 32'd9, 32'd0,
         32'd5, 32'd6, 10);
    run1("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
         32'd0, 32'h8000_0000, 10);
    run1("msub", OP_MSUB, 32'd2, 32'd3,
         32'd0, 32'h7FFF_FFFA, 5);

    sb1.push_back(mk("flush", 32'd0, 32'h7FFF_FFFA, 3));
    issue(0, OP_MULT, 32'd5, 32'd5, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    fl1 = 1'b1;
    @(posedge clk); #1;
    fl1 = 1'b0;
    wait_idle(0, "flush");

    issue(0, OP_MTLO, 32'd9, 32'd0, 1'b1);
    probe("flush_mtlo", 32'd0, 32'h7FFF_FFFA);

    sb1.push_back(mk("rst_div", 32'd0, 32'd0, -1));
    issue(0, OP_DIV, 32'd50, 32'd5, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, busy1}, 32'd0);
    check("rst_async_hi", hi1, 32'd0);
    check("rst_async_lo", lo1, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    probe("post_rst", 32'd0, 32'd0);

    run2("w16_multu", OP_MULTU, 32'hFFFF, 32'hFFFF,
         32'hFFFE, 32'h0001, 1);
    run2("w16_mult", OP_MULT, 32'hFFFF, 32'hFFFF,
         32'h0000, 32'h0001, 1);
    run2("w16_div", OP_DIV, 32'hFF9C, 32'd7,
         32'hFFFE, 32'hFFF2, 10);

    repeat (3) @(posedge clk);
    #1;
    check("sb1_left", sb1.size(), 32'd0);
    check("sb2_left", sb2.size(), 32'd0);
    check("pq1_left", pq1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
